// File: rtl/bl_pkg.sv
// Shared types and constants for the backlight zone calculator.
// Holds the FSM state encoding, dimming-mode bit positions and the enhancement shift.
package bl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      CALC = 2'd2,
      OUT  = 2'd3
   } blState_e;

   localparam int MODE_MAX   = 0;
   localparam int MODE_AVG   = 1;
   localparam int MODE_WB    = 2;
   localparam int MODE_ENHA  = 3;

   localparam int ENHA_SHIFT = 2;

endpackage

// File: rtl/bl_enhance.sv
// Saturating gain: enhanced = min(2^DW-1, avg + avg>>ENHA_SHIFT); purely combinational,
// zero latency, no flow control.
module bl_enhance #(
   parameter int DW = 8
) (
   input  logic [DW-1:0] avg,
   output logic [DW-1:0] enhanced
);
   import bl_pkg::*;

   logic [DW-1:0] gain;
   logic [DW:0]   boosted;

   assign gain     = avg >> ENHA_SHIFT;
   assign boosted  = {1'b0, avg} + {1'b0, gain};
   assign enhanced = boosted[DW] ? {DW{1'b1}} : boosted[DW-1:0];

endmodule

// File: rtl/backlight_zone_calc.sv
// Per-zone backlight level (MAX/AVG/WB/AVG+Enha, enhancement only with BL_ENHA_EN); oBLValid 2 edges
// after the last zone pixel; pixels stall (oPixReady=0) outside ACC, result held until iBLReady.
module backlight_zone_calc #(
   parameter int ZONE_PIX = 64,
   parameter int DW       = 8
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic [3:0]    iMode,
   input  logic          iPixValid,
   input  logic [DW-1:0] iPixY,
   output logic          oPixReady,
   output logic          oBLValid,
   input  logic          iBLReady,
   output logic [DW-1:0] oBL
);
   import bl_pkg::*;

   localparam int LOG2PIX = $clog2(ZONE_PIX);
   localparam int SW      = DW + LOG2PIX;

   blState_e           state;
   logic [3:0]         zoneMode;
   logic [LOG2PIX-1:0] pixCnt;
   logic [DW-1:0]      maxY;
   logic [SW-1:0]      sum;
   logic [DW-1:0]      avgReg;
   logic               calcStep;

   logic               pixAccept;
   logic [DW-1:0]      enhaLevel;
   logic [DW:0]        wbSum;
   logic [DW-1:0]      result;

   assign pixAccept = iPixValid & oPixReady;

`ifdef BL_ENHA_EN
   bl_enhance #(.DW(DW)) uEnhance (
      .avg      (avgReg),
      .enhanced (enhaLevel)
   );
`else
   assign enhaLevel = avgReg;
`endif

   assign wbSum = {1'b0, maxY} + {1'b0, avgReg} + {{DW{1'b0}}, 1'b1};

   always_comb begin
      result = avgReg;
      if (zoneMode[MODE_MAX])       result = maxY;
      else if (zoneMode[MODE_AVG])  result = avgReg;
      else if (zoneMode[MODE_WB])   result = wbSum[DW:1];
      else if (zoneMode[MODE_ENHA]) result = enhaLevel;
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state     <= IDLE;
         zoneMode  <= '0;
         pixCnt    <= '0;
         maxY      <= '0;
         sum       <= '0;
         avgReg    <= '0;
         calcStep  <= 1'b0;
         oPixReady <= 1'b0;
         oBLValid  <= 1'b0;
         oBL       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (iMode != 4'b0000) begin
                  state     <= ACC;
                  oPixReady <= 1'b1;
                  zoneMode  <= iMode;
                  pixCnt    <= '0;
                  maxY      <= '0;
                  sum       <= '0;
               end
            end
            ACC: begin
               if (iMode == 4'b0000) begin
                  state     <= IDLE;
                  oPixReady <= 1'b0;
               end else if (pixAccept) begin
                  pixCnt <= pixCnt + 1'b1;
                  sum    <= sum + SW'(iPixY);
                  if (iPixY > maxY) maxY <= iPixY;
                  if (pixCnt == LOG2PIX'(ZONE_PIX - 1)) begin
                     state     <= CALC;
                     oPixReady <= 1'b0;
                     calcStep  <= 1'b0;
                  end
               end
            end
            // avg is registered before the mode mux so the adder chain stays off the output path
            CALC: begin
               if (!calcStep) begin
                  avgReg   <= sum[SW-1:LOG2PIX];
                  calcStep <= 1'b1;
               end else begin
                  oBL      <= result;
                  oBLValid <= 1'b1;
                  state    <= OUT;
               end
            end
            OUT: begin
               if (iBLReady) begin
                  oBLValid <= 1'b0;
                  if (iMode != 4'b0000) begin
                     state     <= ACC;
                     oPixReady <= 1'b1;
                     zoneMode  <= iMode;
                     pixCnt    <= '0;
                     maxY      <= '0;
                     sum       <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_backlight_zone_calc.sv
// Randomised bench for backlight_zone_calc against a queue-free arithmetic reference model.
module tb_backlight_zone_calc;

   localparam int ZONE_PIX = 64;
   localparam int DW       = 8;

   logic          iCLK = 1'b0;
   logic          iRST = 1'b0;
   logic [3:0]    iMode = 4'b0000;
   logic          iPixValid = 1'b0;
   logic [DW-1:0] iPixY = '0;
   logic          iBLReady = 1'b0;
   logic          oPixReady;
   logic          oBLValid;
   logic [DW-1:0] oBL;

   int     vectors = 0;
   int     miscompares = 0;
   int     pixVals[ZONE_PIX];
   longint lastAccTime = 0;

   always #5 iCLK = ~iCLK;

   backlight_zone_calc #(.ZONE_PIX(ZONE_PIX), .DW(DW)) dut (
      .iCLK      (iCLK),
      .iRST      (iRST),
      .iMode     (iMode),
      .iPixValid (iPixValid),
      .iPixY     (iPixY),
      .oPixReady (oPixReady),
      .oBLValid  (oBLValid),
      .iBLReady  (iBLReady),
      .oBL       (oBL)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // Reference: backlight level of one zone from plain arithmetic over its pixel list.
   function automatic int refBL(input logic [3:0] m);
      int mx = 0;
      int total = 0;
      int avg;
      for (int i = 0; i < ZONE_PIX; i++) begin
         total += pixVals[i];
         if (pixVals[i] > mx) mx = pixVals[i];
      end
      avg = total / ZONE_PIX;
      if (m[0]) return mx;
      if (m[1]) return avg;
      if (m[2]) return (mx + avg + 1) / 2;
`ifdef BL_ENHA_EN
      return (avg + avg / 4 > 255) ? 255 : avg + avg / 4;
`else
      return avg;
`endif
   endfunction

   task automatic fillRandom(input int lo, input int hi);
      for (int i = 0; i < ZONE_PIX; i++) pixVals[i] = int'($urandom_range(hi, lo));
   endtask

   task automatic feed(input int n, input bit scramble, input int gapPct, output bit timedOut);
      int   idx = 0;
      int   guard = 0;
      bit   v;
      logic rdy;
      timedOut = 1'b0;
      while (idx < n) begin
         @(negedge iCLK);
         guard++;
         if (guard > 4000) begin
            timedOut = 1'b1;
            break;
         end
         if (scramble && idx > 0) iMode = 4'($urandom_range(15, 1));
         v         = ($urandom_range(99, 0) >= gapPct);
         iPixValid = v;
         iPixY     = 8'(pixVals[idx]);
         rdy       = oPixReady;
         @(posedge iCLK);
         if (v && rdy) begin
            idx++;
            lastAccTime = longint'($time);
         end
      end
   endtask

   task automatic waitResult(output int lat, output int bl, output bit timedOut);
      timedOut = 1'b1;
      lat = -1;
      bl = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge iCLK);
         iPixValid = 1'b0;
         if (oBLValid === 1'b1) begin
            lat = int'((longint'($time) - 5 - lastAccTime) / 10);
            bl = int'(oBL);
            timedOut = 1'b0;
            break;
         end
      end
   endtask

   task automatic handshake(input logic [3:0] nextMode);
      iMode = nextMode;
      iBLReady = 1'b1;
      @(posedge iCLK);
      @(negedge iCLK);
      iBLReady = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge iCLK);
      vectors++;
      if (oPixReady !== 1'b0) begin miscompares++; $display("FAIL reset_pixready: got %b expected 0", oPixReady); end
      vectors++;
      if (oBLValid !== 1'b0) begin miscompares++; $display("FAIL reset_blvalid: got %b expected 0", oBLValid); end
      vectors++;
      if (oBL !== 8'd0) begin miscompares++; $display("FAIL reset_bl: got %0d expected 0", oBL); end
      iRST = 1'b1;
      repeat (3) @(negedge iCLK);
      vectors++;
      if (oPixReady !== 1'b0) begin miscompares++; $display("FAIL idle_pixready: got %b expected 0", oPixReady); end
   endtask

   task automatic test_max_ramp;
      bit to1, to2;
      int lat, bl;
      for (int i = 0; i < ZONE_PIX; i++) pixVals[i] = i;
      iMode = 4'b0001;
      feed(ZONE_PIX, 1'b0, 20, to1);
      waitResult(lat, bl, to2);
      vectors++;
      if (to1 || to2) begin miscompares++; $display("FAIL ramp_timeout: got feed=%0d wait=%0d expected 0 0", to1, to2); end
      vectors++;
      if (bl !== 63) begin miscompares++; $display("FAIL ramp_bl: got %0d expected 63", bl); end
      vectors++;
      if (lat !== 2) begin miscompares++; $display("FAIL ramp_latency: got %0d expected 2", lat); end
      vectors++;
      if (oPixReady !== 1'b0) begin miscompares++; $display("FAIL ramp_out_pixready: got %b expected 0", oPixReady); end
      handshake(4'b0000);
      vectors++;
      if ({oBLValid, oPixReady} !== 2'b00) begin miscompares++; $display("FAIL ramp_to_idle: got %b expected 00", {oBLValid, oPixReady}); end
   endtask

   task automatic test_directed;
      logic [3:0] modes[3] = '{4'b0010, 4'b0100, 4'b1000};
      int         expect_[3];
      bit         to1, to2;
      int         lat, bl;
`ifdef BL_ENHA_EN
      expect_ = '{100, 129, 255};
`else
      expect_ = '{100, 129, 240};
`endif
      for (int z = 0; z < 3; z++) begin
         for (int i = 0; i < ZONE_PIX; i++) pixVals[i] = (z == 0) ? 100 : (z == 2) ? 240 : 0;
         if (z == 1) pixVals[$urandom_range(ZONE_PIX - 1, 0)] = 255;
         iMode = modes[z];
         feed(ZONE_PIX, 1'b1, 30, to1);
         waitResult(lat, bl, to2);
         vectors++;
         if (to1 || to2 || bl !== expect_[z] || lat !== 2) begin
            miscompares++;
            $display("FAIL directed_mode%b: got bl=%0d lat=%0d to=%0d%0d expected bl=%0d lat=2 to=00",
                     modes[z], bl, lat, to1, to2, expect_[z]);
         end
         handshake(4'b0000);
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0] m, nextM;
      bit         to1, to2;
      int         lat, bl, exp_;
      m = 4'($urandom_range(15, 1));
      iMode = m;
      for (int z = 0; z < 10; z++) begin
         if (z % 3 == 2) fillRandom(200, 255);
         else fillRandom(0, 255);
         exp_ = refBL(m);
         feed(ZONE_PIX, 1'b1, (z % 2) ? 0 : 40, to1);
         waitResult(lat, bl, to2);
         vectors++;
         if (to1 || to2 || bl !== exp_ || lat !== 2) begin
            miscompares++;
            $display("FAIL b2b_zone%0d_mode%b: got bl=%0d lat=%0d to=%0d%0d expected bl=%0d lat=2 to=00",
                     z, m, bl, lat, to1, to2, exp_);
         end
         nextM = (z == 9) ? 4'b0000 : 4'($urandom_range(15, 1));
         handshake(nextM);
         vectors++;
         if (oPixReady !== (nextM != 4'b0000)) begin
            miscompares++;
            $display("FAIL b2b_restart%0d: got pixready=%b expected %b", z, oPixReady, nextM != 4'b0000);
         end
         m = nextM;
      end
   endtask

   task automatic test_stall;
      bit to1, to2;
      int lat, bl, bl0, exp_;
      fillRandom(0, 200);
      exp_ = refBL(4'b0001);
      iMode = 4'b0001;
      feed(ZONE_PIX, 1'b0, 10, to1);
      waitResult(lat, bl0, to2);
      vectors++;
      if (to1 || to2 || bl0 !== exp_) begin miscompares++; $display("FAIL stall_first: got %0d expected %0d", bl0, exp_); end
      iPixValid = 1'b1;
      iPixY = 8'd255;
      iMode = 4'b0010;
      for (int c = 0; c < 10; c++) begin
         @(negedge iCLK);
         vectors++;
         if (oBLValid !== 1'b1 || int'(oBL) !== bl0 || oPixReady !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold%0d: got valid=%b bl=%0d ready=%b expected 1 %0d 0", c, oBLValid, oBL, oPixReady, bl0);
         end
      end
      iPixValid = 1'b0;
      fillRandom(0, 200);
      exp_ = refBL(4'b0001);
      handshake(4'b0001);
      feed(ZONE_PIX, 1'b0, 10, to1);
      waitResult(lat, bl, to2);
      vectors++;
      if (to1 || to2 || bl !== exp_ || lat !== 2) begin
         miscompares++;
         $display("FAIL stall_next: got bl=%0d lat=%0d expected bl=%0d lat=2", bl, lat, exp_);
      end
      handshake(4'b0000);
   endtask

   task automatic test_abort;
      bit to1, to2;
      int lat, bl, exp_;
      for (int i = 0; i < ZONE_PIX; i++) pixVals[i] = 255;
      iMode = 4'b0010;
      feed(30, 1'b0, 0, to1);
      @(negedge iCLK);
      iMode = 4'b0000;
      iPixValid = 1'b0;
      @(negedge iCLK);
      vectors++;
      if (oPixReady !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got pixready=%b expected 0", oPixReady); end
      for (int c = 0; c < 8; c++) begin
         @(negedge iCLK);
         vectors++;
         if (oBLValid !== 1'b0) begin miscompares++; $display("FAIL abort_novalid%0d: got %b expected 0", c, oBLValid); end
      end
      fillRandom(0, 100);
      exp_ = refBL(4'b0001);
      iMode = 4'b0001;
      feed(ZONE_PIX, 1'b1, 25, to1);
      waitResult(lat, bl, to2);
      vectors++;
      if (to1 || to2 || bl !== exp_ || lat !== 2) begin
         miscompares++;
         $display("FAIL abort_next: got bl=%0d lat=%0d expected bl=%0d lat=2", bl, lat, exp_);
      end
      handshake(4'b0000);
   endtask

   task automatic test_reset_mid;
      bit to1, to2;
      int lat, bl, exp_;
      for (int i = 0; i < ZONE_PIX; i++) pixVals[i] = 250;
      iMode = 4'b0001;
      feed(20, 1'b0, 0, to1);
      @(negedge iCLK);
      iPixValid = 1'b0;
      iRST = 1'b0;
      #1;
      vectors++;
      if ({oPixReady, oBLValid} !== 2'b00 || oBL !== 8'd0) begin
         miscompares++;
         $display("FAIL midreset_outputs: got ready=%b valid=%b bl=%0d expected 0 0 0", oPixReady, oBLValid, oBL);
      end
      repeat (2) @(negedge iCLK);
      iRST = 1'b1;
      fillRandom(0, 120);
      exp_ = refBL(4'b0100);
      iMode = 4'b0100;
      feed(ZONE_PIX, 1'b1, 20, to1);
      waitResult(lat, bl, to2);
      vectors++;
      if (to1 || to2 || bl !== exp_ || lat !== 2) begin
         miscompares++;
         $display("FAIL midreset_next: got bl=%0d lat=%0d expected bl=%0d lat=2", bl, lat, exp_);
      end
      handshake(4'b0000);
   endtask

   initial begin
      test_reset();
      test_max_ramp();
      test_directed();
      test_back_to_back();
      test_stall();
      test_abort();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
